// File: rtl/l15_req_port_scheduler_pkg.sv
// Shared numbering and types for the L1.5 request path: the scheduler,
// the L1.5 request encoder and the return decoder all import this package
// so that a port id means the same requester everywhere.
package l15_req_port_scheduler_pkg;

  localparam int unsigned NUM_REQ_PORTS = 6;
  localparam int unsigned REQ_PORTID_W  = $clog2(NUM_REQ_PORTS);

  typedef logic [REQ_PORTID_W-1:0] req_portid_t;

  // Requester numbering; lower index means higher priority.
  localparam req_portid_t ICACHE   = req_portid_t'(0);
  localparam req_portid_t DCACHE   = req_portid_t'(1);
  localparam req_portid_t WBUF     = req_portid_t'(2);
  localparam req_portid_t UC_READ  = req_portid_t'(3);
  localparam req_portid_t UC_WRITE = req_portid_t'(4);
  localparam req_portid_t AMO      = req_portid_t'(5);

  // Output slot state: IDLE = slot empty, HOLD = slot presented to L1.5.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

endpackage

// File: rtl/l15_req_port_scheduler_if.sv
// Request-side, L1.5-side and return handshakes of the request scheduler.
// The scheduler uses the slave modport; the surrounding logic uses master.
interface l15_req_port_scheduler_if #(
  parameter int unsigned NumPorts  = 6,
  parameter int unsigned DataWidth = 128
);

  localparam int unsigned IdW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [NumPorts-1:0]           req_valid_i;
  logic [NumPorts-1:0]           req_ready_o;
  logic [NumPorts*DataWidth-1:0] req_data_i;
  logic                          out_valid_o;
  logic                          out_ack_i;
  logic [DataWidth-1:0]          out_data_o;
  logic [IdW-1:0]                out_portid_o;
  logic                          rtrn_valid_i;
  logic [IdW-1:0]                rtrn_portid_i;

  modport slave (
    input  req_valid_i, req_data_i, out_ack_i, rtrn_valid_i, rtrn_portid_i,
    output req_ready_o, out_valid_o, out_data_o, out_portid_o
  );

  modport master (
    output req_valid_i, req_data_i, out_ack_i, rtrn_valid_i, rtrn_portid_i,
    input  req_ready_o, out_valid_o, out_data_o, out_portid_o
  );

endinterface

// File: rtl/l15_prio_picker.sv
// Lowest-index-wins onehot picker. vld is set when any request bit is set.
module l15_prio_picker #(
  parameter int unsigned Width = 6
) (
  input  logic [Width-1:0] req,
  output logic [Width-1:0] gnt,
  output logic             vld
);

  // Scan from index 0 upward and grant the first set bit only.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int i = 0; i < Width; i++) begin
      if (req[i] && !vld) begin
        gnt[i] = 1'b1;
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l15_req_port_scheduler.sv
// L1.5 request slot scheduler: fixed priority with starvation promotion,
// per-port credit limit on outstanding transactions, and a single output
// register holding the request currently offered to L1.5.
module l15_req_port_scheduler
  import l15_req_port_scheduler_pkg::*;
#(
  parameter int unsigned NumPorts       = 6,
  parameter int unsigned DataWidth      = 128,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned StarveTh       = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  l15_req_port_scheduler_if.slave  bus,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int unsigned IdW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned CreditW = $clog2(MaxOutstanding + 1);
  localparam int unsigned WaitW   = (StarveTh > 0) ? $clog2(StarveTh + 1) : 1;
  localparam logic [CreditW:0]  CreditLim = (CreditW + 1)'(MaxOutstanding);
  localparam logic [WaitW-1:0]  WaitMax   = WaitW'(StarveTh);
  localparam bit                AgingOn   = (StarveTh != 0);

  sched_state_t         state_q, state_d;
  logic [DataWidth-1:0] out_data_q;
  logic [IdW-1:0]       out_portid_q;
  logic                 err_q;

  logic [CreditW-1:0]   credit_q    [NumPorts];
  logic [CreditW:0]     credit_post [NumPorts];
  logic [WaitW-1:0]     wait_q      [NumPorts];

  logic                 ack_fire, rtrn_fire, accept;
  logic [NumPorts-1:0]  ack_sel, rtrn_sel, underflow, credit_used;
  logic [NumPorts-1:0]  eligible, promoted, grant;
  logic [NumPorts-1:0]  prom_gnt, elig_gnt, win_gnt;
  logic                 prom_vld, elig_vld, win_vld;
  logic [IdW-1:0]       win_id;
  logic [DataWidth-1:0] win_data;

  function automatic logic [IdW-1:0] onehot_to_idx(input logic [NumPorts-1:0] oh);
    logic [IdW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (oh[i]) idx = idx | IdW'(i);
    end
    return idx;
  endfunction

  // An ack only counts while the slot is actually presented.
  assign ack_fire  = (state_q == HOLD) && bus.out_ack_i;
  assign rtrn_fire = bus.rtrn_valid_i && (32'(bus.rtrn_portid_i) < NumPorts);

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign ack_sel[p]     = ack_fire  && (out_portid_q == IdW'(p));
    assign rtrn_sel[p]    = rtrn_fire && (bus.rtrn_portid_i == IdW'(p));
    // Eligibility sees the credit this cycle's ack is about to consume.
    assign credit_post[p] = {1'b0, credit_q[p]} + {{CreditW{1'b0}}, ack_sel[p]};
    assign eligible[p]    = bus.req_valid_i[p] && (credit_post[p] < CreditLim);
    assign promoted[p]    = AgingOn && eligible[p] && (wait_q[p] == WaitMax);
    assign underflow[p]   = rtrn_sel[p] && !ack_sel[p] && (credit_q[p] == '0);
    assign credit_used[p] = (credit_q[p] != '0);

    // Outstanding count: +1 on ack, -1 on return, never below zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        credit_q[p] <= '0;
      end else if (ack_sel[p] && !rtrn_sel[p]) begin
        credit_q[p] <= credit_q[p] + 1'b1;
      end else if (!ack_sel[p] && rtrn_sel[p] && (credit_q[p] != '0)) begin
        credit_q[p] <= credit_q[p] - 1'b1;
      end
    end

    // Age a port only while it is eligible and losing arbitration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wait_q[p] <= '0;
      end else if (!bus.req_valid_i[p] || grant[p]) begin
        wait_q[p] <= '0;
      end else if (AgingOn && eligible[p] && (wait_q[p] != WaitMax)) begin
        wait_q[p] <= wait_q[p] + 1'b1;
      end
    end
  end

  l15_prio_picker #(.Width(NumPorts)) u_prom_pick (
    .req (promoted),
    .gnt (prom_gnt),
    .vld (prom_vld)
  );

  l15_prio_picker #(.Width(NumPorts)) u_elig_pick (
    .req (eligible),
    .gnt (elig_gnt),
    .vld (elig_vld)
  );

  assign win_gnt = prom_vld ? prom_gnt : elig_gnt;
  assign win_vld = prom_vld || elig_vld;
  assign win_id  = onehot_to_idx(win_gnt);
  // The slot can be refilled when empty, or in the cycle it is being acked.
  assign accept  = rst_ni && win_vld && ((state_q == IDLE) || ack_fire);
  assign grant   = accept ? win_gnt : '0;

  // Select the winning payload from the flattened request bus.
  always_comb begin
    win_data = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (win_gnt[p]) win_data = win_data | bus.req_data_i[p*DataWidth +: DataWidth];
    end
  end

  // Slot FSM: load on accept, drain on ack when nothing else is waiting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = HOLD;
      HOLD:    if (ack_fire) state_d = accept ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Output register: payload and source port of the accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q   <= '0;
      out_portid_q <= '0;
    end else if (accept) begin
      out_data_q   <= win_data;
      out_portid_q <= win_id;
    end
  end

  // Sticky flag for a return that arrived with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         err_q <= 1'b0;
    else if (|underflow) err_q <= 1'b1;
  end

  assign bus.req_ready_o  = grant;
  assign bus.out_valid_o  = (state_q == HOLD);
  assign bus.out_data_o   = out_data_q;
  assign bus.out_portid_o = out_portid_q;
  assign busy_o           = (state_q == HOLD) || (|credit_used);
  assign err_o            = err_q;

endmodule

// File: tb/tb_l15_req_port_scheduler.sv
// Directed bench for l15_req_port_scheduler (MaxOutstanding=4, StarveTh=8).
module tb_l15_req_port_scheduler;
  import l15_req_port_scheduler_pkg::*;

  localparam int NP = 6;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  l15_req_port_scheduler_if #(.NumPorts(NP), .DataWidth(DW)) bus ();

  l15_req_port_scheduler #(
    .NumPorts(NP), .DataWidth(DW), .MaxOutstanding(4), .StarveTh(8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .busy_o (busy),
    .err_o  (err)
  );

  typedef struct {
    logic [5:0] valid;
    logic       ack;
    logic       rv;
    logic [2:0] rp;
    logic [5:0] exp_ready;
    logic       exp_ov;
    logic [2:0] exp_pid;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [DW-1:0] payload(input int p);
    return {4{32'h5EED_0000 + 32'(p)}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_valid_i   = '0;
    bus.out_ack_i     = 1'b0;
    bus.rtrn_valid_i  = 1'b0;
    bus.rtrn_portid_i = '0;
    for (int p = 0; p < NP; p++) bus.req_data_i[p*DW +: DW] = payload(p);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  // Port 0 and port 5 request; port 0 is kept at zero credit by returning
  // each of its transfers as it is acked. Reports cycles port 5 waited.
  task automatic measure_starve(output int n);
    bit got;
    got = 1'b0;
    n = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      bus.req_valid_i   = {1'b1, 4'b0000, 1'b1};
      bus.out_ack_i     = 1'b1;
      bus.rtrn_valid_i  = bus.out_valid_o && (bus.out_portid_o == ICACHE);
      bus.rtrn_portid_i = ICACHE;
      #1;
      if (bus.req_ready_o[AMO]) begin
        got = 1'b1;
        n = i;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cnt;
    logic [DW-1:0] d3b;

    //             valid      ack  rv   rp    ready      ov   pid   busy err
    tbl[0] = '{6'b101010, 1'b1, 1'b0, 3'd0, 6'b000010, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{6'b101000, 1'b1, 1'b0, 3'd0, 6'b001000, 1'b1, 3'd1, 1'b1, 1'b0};
    tbl[2] = '{6'b100000, 1'b1, 1'b0, 3'd0, 6'b100000, 1'b1, 3'd3, 1'b1, 1'b0};
    tbl[3] = '{6'b000000, 1'b1, 1'b0, 3'd0, 6'b000000, 1'b1, 3'd5, 1'b1, 1'b0};
    tbl[4] = '{6'b000000, 1'b1, 1'b1, 3'd1, 6'b000000, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[5] = '{6'b000000, 1'b0, 1'b1, 3'd4, 6'b000000, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[6] = '{6'b000000, 1'b0, 1'b1, 3'd7, 6'b000000, 1'b0, 3'd5, 1'b1, 1'b1};
    tbl[7] = '{6'b000000, 1'b0, 1'b1, 3'd3, 6'b000000, 1'b0, 3'd5, 1'b1, 1'b1};
    tbl[8] = '{6'b000000, 1'b0, 1'b1, 3'd5, 6'b000000, 1'b0, 3'd5, 1'b1, 1'b1};
    tbl[9] = '{6'b000000, 1'b0, 1'b0, 3'd0, 6'b000000, 1'b0, 3'd5, 1'b0, 1'b1};

    // Reset held with every port requesting.
    clear_inputs();
    bus.req_valid_i = '1;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    check("rst_ready", bus.req_ready_o, '0);
    check("rst_out_valid", bus.out_valid_o, 1'b0);
    check("rst_out_data", bus.out_data_o, '0);
    check("rst_out_portid", bus.out_portid_o, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("rel_ready", bus.req_ready_o, 6'b000001);
    next_cycle();
    #1;
    check("rel_out_valid", bus.out_valid_o, 1'b1);
    check("rel_out_portid", bus.out_portid_o, ICACHE);
    check("rel_out_data", bus.out_data_o, payload(0));

    // Priority order, credit bookkeeping, dropped/out-of-range returns.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.req_valid_i   = tbl[i].valid;
      bus.out_ack_i     = tbl[i].ack;
      bus.rtrn_valid_i  = tbl[i].rv;
      bus.rtrn_portid_i = tbl[i].rp;
      #1;
      check($sformatf("vec%0d_ready", i), bus.req_ready_o, tbl[i].exp_ready);
      check($sformatf("vec%0d_out_valid", i), bus.out_valid_o, tbl[i].exp_ov);
      check($sformatf("vec%0d_out_portid", i), bus.out_portid_o, tbl[i].exp_pid);
      if (tbl[i].exp_ov)
        check($sformatf("vec%0d_out_data", i), bus.out_data_o, payload(int'(tbl[i].exp_pid)));
      check($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
      check($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
      next_cycle();
    end

    // Credit cap on port 2, then one return releases exactly one accept.
    do_reset();
    bus.req_valid_i = 6'b000100;
    bus.out_ack_i   = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.req_ready_o[WBUF]) cnt++;
      next_cycle();
    end
    check("cap_accepts", cnt, 4);
    bus.rtrn_valid_i  = 1'b1;
    bus.rtrn_portid_i = WBUF;
    #1;
    check("cap_rtrn_cycle_ready", bus.req_ready_o, '0);
    next_cycle();
    bus.rtrn_valid_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.req_ready_o[WBUF]) cnt++;
      next_cycle();
    end
    check("cap_after_rtrn_accepts", cnt, 1);
    check("cap_busy", busy, 1'b1);
    check("cap_err", err, 1'b0);

    // Starvation promotion from a clean reset.
    do_reset();
    measure_starve(cnt);
    check("starve_wait", cnt, 8);

    // Backpressure: slot frozen while ack is low.
    do_reset();
    bus.req_valid_i = 6'b001000;
    #1;
    check("bp_first_ready", bus.req_ready_o, 6'b001000);
    next_cycle();
    d3b = ~payload(3);
    bus.req_data_i[3*DW +: DW] = d3b;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_out_valid", i), bus.out_valid_o, 1'b1);
      check($sformatf("bp%0d_out_data", i), bus.out_data_o, payload(3));
      check($sformatf("bp%0d_out_portid", i), bus.out_portid_o, UC_READ);
      check($sformatf("bp%0d_ready", i), bus.req_ready_o, '0);
      next_cycle();
    end
    bus.out_ack_i = 1'b1;
    #1;
    check("bp_ack_reload_ready", bus.req_ready_o, 6'b001000);
    next_cycle();
    // Ack and return on port 3 together: credit stays at 1.
    bus.req_valid_i   = '0;
    bus.rtrn_valid_i  = 1'b1;
    bus.rtrn_portid_i = UC_READ;
    #1;
    check("bp_reload_data", bus.out_data_o, d3b);
    check("bp_reload_portid", bus.out_portid_o, UC_READ);
    next_cycle();
    bus.out_ack_i = 1'b0;
    next_cycle();
    bus.rtrn_valid_i = 1'b0;
    #1;
    check("sim_busy", busy, 1'b0);
    check("sim_err", err, 1'b0);
    bus.rtrn_valid_i  = 1'b1;
    bus.rtrn_portid_i = UC_WRITE;
    next_cycle();
    bus.rtrn_valid_i = 1'b0;
    #1;
    check("underflow_err", err, 1'b1);
    check("underflow_busy", busy, 1'b0);

    // Async reset in the middle of a transfer.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.req_valid_i   = {1'b1, 4'b0000, 1'b1};
      bus.out_ack_i     = 1'b1;
      bus.rtrn_valid_i  = bus.out_valid_o && (bus.out_portid_o == ICACHE);
      bus.rtrn_portid_i = ICACHE;
      next_cycle();
    end
    bus.rtrn_valid_i = 1'b0;
    next_cycle();
    bus.out_ack_i = 1'b0;
    #1;
    check("pre_arst_out_valid", bus.out_valid_o, 1'b1);
    check("pre_arst_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid_o, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", bus.req_ready_o, '0);
    next_cycle();
    rst_n = 1'b1;
    measure_starve(cnt);
    check("arst_starve_wait", cnt, 8);
    check("arst_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
